// File: rtl/rr_adder_sched.sv
// Round-robin issue of an add-request stream onto a bank of fixed-latency adders.
// Results return in issue order; end of data drains the bank and raises drain_done.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 32
`endif

module rr_adder_sched #(
  parameter int NUM_ADDER      = 4,
  parameter int ADD_LAT        = 4,
  parameter int BITS_ROW_IDX   = `BITS_ROW_IDX,
  parameter int DATA_PRECISION = `DATA_PRECISION
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BITS_ROW_IDX-1:0]                in_row_idx,
  input  logic [DATA_PRECISION-1:0]              in_op0,
  input  logic [DATA_PRECISION-1:0]              in_op1,
  input  logic                                   data_ended,
  output logic [NUM_ADDER-1:0]                   add_start,
  output logic [DATA_PRECISION-1:0]              add_op0,
  output logic [DATA_PRECISION-1:0]              add_op1,
  input  logic [NUM_ADDER*DATA_PRECISION-1:0]    add_result,
  output logic                                   out_valid,
  output logic [BITS_ROW_IDX+DATA_PRECISION-1:0] out_data,
  output logic [$clog2(NUM_ADDER+1)-1:0]         in_flight,
  output logic                                   drain_done
);

  localparam int PW = (NUM_ADDER > 1) ? $clog2(NUM_ADDER) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);
  localparam int IW = $clog2(NUM_ADDER + 1);
  localparam int RW = BITS_ROW_IDX;
  localparam int DW = DATA_PRECISION;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [NUM_ADDER-1:0] busy_r;
  logic [CW-1:0]        cnt_r [NUM_ADDER];
  logic [RW-1:0]        row_r [NUM_ADDER];
  logic [PW-1:0]        ptr_r;
  logic [NUM_ADDER-1:0] done_vec_s;
  logic                 accept_s;
  logic                 cmp_s;
  logic [RW-1:0]        cmp_row_s;
  logic [DW-1:0]        cmp_sum_s;
  logic                 bank_empty_s;

  // A slot is reusable in the very cycle its result is being retired.
  assign in_ready     = (state_r == ST_RUN) &&
                        (!busy_r[ptr_r] || (cnt_r[ptr_r] == CW'(1'b1)));
  assign accept_s     = in_valid && in_ready;
  assign add_op0      = in_op0;
  assign add_op1      = in_op1;
  assign bank_empty_s = (busy_r == {NUM_ADDER{1'b0}});

  // Start strobe and per-slot completion flags.
  always_comb begin
    add_start  = '0;
    done_vec_s = '0;
    for (int i = 0; i < NUM_ADDER; i++) begin
      add_start[i]  = accept_s && (ptr_r == PW'(i));
      done_vec_s[i] = busy_r[i] && (cnt_r[i] == CW'(1'b1));
    end
  end

  // Rotational issue guarantees at most one completion, so an AND-OR mux suffices.
  always_comb begin
    cmp_row_s = '0;
    cmp_sum_s = '0;
    for (int i = 0; i < NUM_ADDER; i++) begin
      cmp_row_s = cmp_row_s | ({RW{done_vec_s[i]}} & row_r[i]);
      cmp_sum_s = cmp_sum_s | ({DW{done_vec_s[i]}} & add_result[i*DW +: DW]);
    end
    cmp_s = |done_vec_s;
  end

  // Next-state logic: RUN -> DRAIN on end of data, DRAIN -> DONE once the bank is empty.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (data_ended) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bank_empty_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State register and sticky drain_done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      drain_done <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_DRAIN) && bank_empty_s) begin
        drain_done <= 1'b1;
      end else begin
        drain_done <= drain_done;
      end
    end
  end

  // Slot bookkeeping; a re-issue into a retiring slot takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r  <= '0;
      busy_r <= '0;
      for (int i = 0; i < NUM_ADDER; i++) begin
        cnt_r[i] <= '0;
        row_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        ptr_r <= (ptr_r == PW'(NUM_ADDER - 1)) ? '0 : ptr_r + PW'(1'b1);
      end else begin
        ptr_r <= ptr_r;
      end
      for (int i = 0; i < NUM_ADDER; i++) begin
        if (accept_s && (ptr_r == PW'(i))) begin
          busy_r[i] <= 1'b1;
          cnt_r[i]  <= CW'(ADD_LAT);
          row_r[i]  <= in_row_idx;
        end else if (done_vec_s[i]) begin
          busy_r[i] <= 1'b0;
          cnt_r[i]  <= '0;
        end else if (busy_r[i]) begin
          cnt_r[i] <= cnt_r[i] - CW'(1'b1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Registered result port and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      in_flight <= '0;
    end else begin
      out_valid <= cmp_s;
      if (cmp_s) begin
        out_data <= {cmp_row_s, cmp_sum_s};
      end else begin
        out_data <= out_data;
      end
      in_flight <= in_flight + IW'(accept_s) - IW'(cmp_s);
    end
  end

endmodule
